// File: rtl/cga_intr_pkg.sv
// Shared definitions for the level-scheduling interrupt controller: FSM encoding,
// default level count and the level-number width helper.
package cga_intr_pkg;

  localparam int unsigned NLEV_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of a level number; never below one bit so a 2-level build still has an index.
  function automatic int unsigned lvlw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cga_intr_cntlr_lvlsched_if.sv
// Level-change handshake between the interrupt controller (slave) and the
// microcode sequencer (master).
interface cga_intr_cntlr_lvlsched_if
  import cga_intr_pkg::*;
#(
  parameter int unsigned NLEV = NLEV_DEF,
  parameter int unsigned LVLW = lvlw(NLEV)
);
  logic            ION;
  logic [LVLW-1:0] PIL;
  logic            ACK;
  logic            INTRQ;
  logic [LVLW-1:0] NEWLVL;

  modport master (output ION, PIL, ACK, input INTRQ, NEWLVL);
  modport slave  (input ION, PIL, ACK, output INTRQ, NEWLVL);
endinterface

// File: rtl/cga_intr_prienc.sv
// Combinational priority encoder: index of the highest set bit plus a valid flag.
module cga_intr_prienc
  import cga_intr_pkg::*;
#(
  parameter int unsigned NLEV = NLEV_DEF,
  parameter int unsigned LVLW = lvlw(NLEV)
) (
  input  logic [NLEV-1:0] vec,
  output logic            valid,
  output logic [LVLW-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NLEV; i++) begin
      if (vec[i]) begin
        valid = 1'b1;
        idx   = LVLW'(i);
      end
    end
  end

endmodule

// File: rtl/cga_intr_cntlr_lvlsched.sv
// Interrupt level scheduler: PID/PIE registers, priority selection and the
// IDLE/REQ/DONE level-change handshake. Optional macro: CGA_INTR_ACK_CLR_EN.
module cga_intr_cntlr_lvlsched
  import cga_intr_pkg::*;
#(
  parameter int unsigned NLEV = NLEV_DEF,
  parameter int unsigned LVLW = lvlw(NLEV)
) (
  input  logic                         MCLK,
  input  logic                         RESETN,
  input  logic [NLEV-1:0]              IREQ,
  input  logic [NLEV-1:0]              FIDB,
  input  logic                         WRPIE,
  input  logic                         CLRPID,
  cga_intr_cntlr_lvlsched_if.slave     hs,
  output logic [NLEV-1:0]              PIDO,
  output logic [NLEV-1:0]              PIEO
);

  logic [1:0]      state;
  logic [NLEV-1:0] pid;
  logic [NLEV-1:0] pie;
  logic [NLEV-1:0] candVec;
  logic [NLEV-1:0] clrMask;
  logic [NLEV-1:0] ackClr;
  logic            candValid;
  logic [LVLW-1:0] candIdx;
  logic            intrq;
  logic [LVLW-1:0] newLvl;
  logic            takeAck;

  // Level 0 is the background level and can never be requested.
  always_comb begin
    candVec    = pid & pie;
    candVec[0] = 1'b0;
  end

  cga_intr_prienc #(
    .NLEV (NLEV),
    .LVLW (LVLW)
  ) uPrienc (
    .vec   (candVec),
    .valid (candValid),
    .idx   (candIdx)
  );

  assign takeAck = (state == ST_REQ) && hs.ION && hs.ACK;
  assign clrMask = CLRPID ? FIDB : '0;

`ifdef CGA_INTR_ACK_CLR_EN
  always_comb begin
    ackClr = '0;
    if (takeAck) ackClr[newLvl] = 1'b1;
  end
`else
  assign ackClr = '0;
`endif

  // Set is OR-ed in last so a same-cycle IREQ beats both clear sources.
  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      pid <= '0;
      pie <= '0;
    end else begin
      pid <= (pid & ~clrMask & ~ackClr) | IREQ;
      if (WRPIE) pie <= FIDB;
    end
  end

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      state  <= ST_IDLE;
      intrq  <= 1'b0;
      newLvl <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs.ION && candValid && (candIdx > hs.PIL)) begin
            state  <= ST_REQ;
            intrq  <= 1'b1;
            newLvl <= candIdx;
          end
        end
        ST_REQ: begin
          if (!hs.ION) begin
            state <= ST_IDLE;
            intrq <= 1'b0;
          end else if (hs.ACK) begin
            state <= ST_DONE;
            intrq <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          intrq <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          intrq <= 1'b0;
        end
      endcase
    end
  end

  assign hs.INTRQ  = intrq;
  assign hs.NEWLVL = newLvl;
  assign PIDO      = pid;
  assign PIEO      = pie;

endmodule

// File: tb/tb_cga_intr_cntlr_lvlsched.sv
// Table-driven bench for cga_intr_cntlr_lvlsched with a queue scoreboard; builds
// with or without CGA_INTR_ACK_CLR_EN.
module tb_cga_intr_cntlr_lvlsched;

  typedef struct {
    logic [15:0] ireq;
    logic [15:0] fidb;
    logic        wrpie;
    logic        clrpid;
    logic        ion;
    logic [3:0]  pil;
    logic        ack;
    logic        eIntrq;
    logic [3:0]  eNl;
    logic [15:0] ePid;
    logic [15:0] ePie;
  } vec_t;

`ifdef CGA_INTR_ACK_CLR_EN
  localparam bit ACKCLR = 1'b1;
`else
  localparam bit ACKCLR = 1'b0;
`endif

  logic        MCLK;
  logic        RESETN;
  logic [15:0] IREQ;
  logic [15:0] FIDB;
  logic        WRPIE;
  logic        CLRPID;
  logic [15:0] PIDO;
  logic [15:0] PIEO;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t expQ[$];

  cga_intr_cntlr_lvlsched_if #(.NLEV(16)) hs ();

  cga_intr_cntlr_lvlsched #(.NLEV(16)) dut (
    .MCLK   (MCLK),
    .RESETN (RESETN),
    .IREQ   (IREQ),
    .FIDB   (FIDB),
    .WRPIE  (WRPIE),
    .CLRPID (CLRPID),
    .hs     (hs.slave),
    .PIDO   (PIDO),
    .PIEO   (PIEO)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [15:0] ireq, fidb, input logic wrpie, clrpid, ion,
                              input logic [3:0] pil, input logic ack, eI,
                              input logic [3:0] eN, input logic [15:0] eP, eE);
    vec_t v;
    v.ireq = ireq; v.fidb = fidb; v.wrpie = wrpie; v.clrpid = clrpid;
    v.ion = ion; v.pil = pil; v.ack = ack;
    v.eIntrq = eI; v.eNl = eN; v.ePid = eP; v.ePie = eE;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: act=%h req=%h", name, idx, act, exp);
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    vec_t e;
    @(negedge MCLK);
    IREQ = v.ireq; FIDB = v.fidb; WRPIE = v.wrpie; CLRPID = v.clrpid;
    hs.ION = v.ion; hs.PIL = v.pil; hs.ACK = v.ack;
    expQ.push_back(v);
    @(posedge MCLK);
    #1;
    e = expQ.pop_front();
    chk("intrq",  idx, {15'd0, hs.INTRQ}, {15'd0, e.eIntrq});
    chk("newlvl", idx, {12'd0, hs.NEWLVL}, {12'd0, e.eNl});
    chk("pido",   idx, PIDO, e.ePid);
    chk("pieo",   idx, PIEO, e.ePie);
  endtask

  initial begin
    logic [15:0] p6, p16, p21;
    p6  = ACKCLR ? 16'h1000 : 16'h1010;
    p16 = ACKCLR ? 16'h0010 : 16'h8010;
    p21 = ACKCLR ? 16'h0000 : 16'h0020;

    // Request at level 4, higher level pends mid-request, then serviced next.
    tbl.push_back(mk(16'h0000, 16'h8010, 1, 0, 1, 4'd2, 0, 0, 4'd0,  16'h0000, 16'h8010));
    tbl.push_back(mk(16'h0010, 16'h0000, 0, 0, 1, 4'd2, 0, 0, 4'd0,  16'h0010, 16'h8010));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd2, 0, 1, 4'd4,  16'h0010, 16'h8010));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd2, 0, 1, 4'd4,  16'h0010, 16'h8010));
    tbl.push_back(mk(16'h1000, 16'hFFFF, 1, 0, 1, 4'd2, 0, 1, 4'd4,  16'h1010, 16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd2, 1, 0, 4'd4,  p6,       16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd2, 0, 0, 4'd4,  p6,       16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd2, 0, 1, 4'd12, p6,       16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 4'd2, 1, 0, 4'd12, p6,       16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 4'd2, 0, 0, 4'd12, p6,       16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'hFFFF, 0, 1, 0, 4'd2, 0, 0, 4'd12, 16'h0000, 16'hFFFF));
    // Priority against PIL, including equal level.
    tbl.push_back(mk(16'h8010, 16'h0000, 0, 0, 0, 4'd15, 0, 0, 4'd12, 16'h8010, 16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd15, 0, 0, 4'd12, 16'h8010, 16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd15, 0, 0, 4'd12, 16'h8010, 16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd0,  0, 1, 4'd15, 16'h8010, 16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd0,  1, 0, 4'd15, p16,      16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 4'd0,  0, 0, 4'd15, p16,      16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'hFFFF, 0, 1, 0, 4'd0,  0, 0, 4'd15, 16'h0000, 16'hFFFF));
    // Set beats clear; ACK ignored outside REQ; WRPIE and CLRPID together.
    tbl.push_back(mk(16'h0020, 16'h0020, 0, 1, 0, 4'd0,  0, 0, 4'd15, 16'h0020, 16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd0,  0, 1, 4'd5,  16'h0020, 16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd0,  1, 0, 4'd5,  p21,      16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 4'd0,  1, 0, 4'd5,  p21,      16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 4'd0,  1, 0, 4'd5,  p21,      16'hFFFF));
    tbl.push_back(mk(16'h0000, 16'h0021, 1, 1, 0, 4'd0,  0, 0, 4'd5,  16'h0000, 16'h0021));
    // IREQ on the acknowledged level in the ACK cycle keeps its PID bit.
    tbl.push_back(mk(16'h0020, 16'h0000, 0, 0, 0, 4'd0,  0, 0, 4'd5,  16'h0020, 16'h0021));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd0,  0, 1, 4'd5,  16'h0020, 16'h0021));
    tbl.push_back(mk(16'h0020, 16'h0000, 0, 0, 1, 4'd0,  1, 0, 4'd5,  16'h0020, 16'h0021));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 4'd0,  0, 0, 4'd5,  16'h0020, 16'h0021));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 4'd0,  0, 1, 4'd5,  16'h0020, 16'h0021));

    RESETN = 1'b1;
    IREQ = '0; FIDB = '0; WRPIE = 1'b0; CLRPID = 1'b0;
    hs.ION = 1'b0; hs.PIL = '0; hs.ACK = 1'b0;
    #2 RESETN = 1'b0;
    #1;
    chk("rst_intrq",  0, {15'd0, hs.INTRQ}, 16'h0000);
    chk("rst_newlvl", 0, {12'd0, hs.NEWLVL}, 16'h0000);
    chk("rst_pido",   0, PIDO, 16'h0000);
    chk("rst_pieo",   0, PIEO, 16'h0000);
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    RESETN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(i + 1, tbl[i]);

    // Asynchronous reset mid-request, well before the next clock edge.
    #2 RESETN = 1'b0;
    #1;
    chk("arst_intrq",  0, {15'd0, hs.INTRQ}, 16'h0000);
    chk("arst_newlvl", 0, {12'd0, hs.NEWLVL}, 16'h0000);
    chk("arst_pido",   0, PIDO, 16'h0000);
    chk("arst_pieo",   0, PIEO, 16'h0000);
    @(posedge MCLK);
    @(negedge MCLK);
    RESETN = 1'b1;
    step(100, mk(16'h0000, 16'h0000, 0, 0, 1, 4'd0, 0, 0, 4'd0, 16'h0000, 16'h0000));
    step(101, mk(16'h0020, 16'h0020, 1, 0, 1, 4'd0, 0, 0, 4'd0, 16'h0020, 16'h0020));
    step(102, mk(16'h0000, 16'h0000, 0, 0, 1, 4'd0, 0, 1, 4'd5, 16'h0020, 16'h0020));

    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: act=%0d req=0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cga_intr_cntlr_lvlsched.md
CGA_INTR_CNTLR_LVLSCHED -- requirements
Module: cga_intr_cntlr_lvlsched

Interface
REQ-001 The block SHALL have parameter NLEV, default 16, number of interrupt levels (power of two, 2..16).
REQ-002 The block SHALL have derived parameter LVLW, default clog2(NLEV) = 4, level-number width.
REQ-003 The block SHALL have port MCLK  in  1  single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESETN  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have port IREQ  in  NLEV  per-level request pulses; bit n high for one cycle sets PID[n].
REQ-006 The block SHALL have port FIDB  in  NLEV  internal data bus value for register writes.
REQ-007 The block SHALL have port WRPIE  in  1  load PIE from FIDB.
REQ-008 The block SHALL have port CLRPID  in  1  clear the PID bits set in FIDB.
REQ-009 The block SHALL have port ION  in  1  interrupt system on; gates all level-change requests.
REQ-010 The block SHALL have port PIL  in  LVLW  current program level.
REQ-011 The block SHALL have port ACK  in  1  microcode acknowledge of a level-change request.
REQ-012 The block SHALL have port INTRQ  out  1  level-change request, registered.
REQ-013 The block SHALL have port NEWLVL  out  LVLW  requested level, registered; valid while INTRQ=1.
REQ-014 The block SHALL have port PIDO  out  NLEV  current PID register.
REQ-015 The block SHALL have port PIEO  out  NLEV  current PIE register.

Function
REQ-016 PID[n] SHALL be set on the cycle after IREQ[n]=1 and cleared on the cycle after CLRPID=1 with FIDB[n]=1; set SHALL win over clear in the same cycle.
REQ-017 PIE SHALL load FIDB on the cycle after WRPIE=1; WRPIE and CLRPID in one cycle SHALL both take effect.
REQ-018 Candidate SHALL be the highest n with PID[n]&PIE[n]=1, level NLEV-1 highest priority; level 0 SHALL never be a candidate.
REQ-019 FSM states SHALL be IDLE, REQ, DONE.
REQ-020 IDLE->REQ SHALL occur when ION=1, a candidate exists and candidate > PIL; NEWLVL SHALL be latched on that edge, so INTRQ=1 one cycle after the condition.
REQ-021 In REQ, INTRQ=1 and NEWLVL SHALL hold stable; a newly pending higher level SHALL NOT preempt it.
REQ-022 REQ->DONE SHALL occur when ACK=1; REQ->IDLE SHALL occur when ION=0 (ION=0 wins over a simultaneous ACK=1).
REQ-023 DONE SHALL last one cycle with INTRQ=0, then return to IDLE; ACK outside REQ SHALL be ignored.
REQ-024 PIE or PID changes during REQ SHALL NOT withdraw INTRQ; re-evaluation SHALL happen only in IDLE.

Reset
REQ-025 RESETN=0 SHALL asynchronously force PID=0, PIE=0, state IDLE, INTRQ=0, NEWLVL=0, PIDO=0, PIEO=0.
REQ-026 Reset removed mid-request SHALL restart in IDLE without INTRQ until a new IDLE->REQ evaluation.

Configuration
REQ-027 With macro CGA_INTR_ACK_CLR_EN defined, the transition into DONE SHALL clear PID[NEWLVL], and a same-cycle IREQ on that level SHALL win.
REQ-028 Without CGA_INTR_ACK_CLR_EN, PID SHALL be cleared only by CLRPID.

Structure
REQ-029 FSM state encoding, NLEV default and the level-width function SHALL live in shared package cga_intr_pkg.
REQ-030 The priority encoder SHALL be a sub-module cga_intr_prienc (NLEV in, valid + LVLW index out, combinational).

Verification
REQ-031 PIE=0x8010, IREQ[4] pulse, PIL=2, ION=1 -> INTRQ=1, NEWLVL=4 two cycles after pulse; ACK -> DONE, INTRQ=0 next cycle.
REQ-032 PID bits 4 and 15 set, PIE=0xFFFF, PIL=0 -> NEWLVL=15; PIL=15 with same PID -> INTRQ stays 0.
REQ-033 In REQ (NEWLVL=4), IREQ[12] pulse -> NEWLVL stays 4 until ACK; next IDLE evaluation gives NEWLVL=12.
REQ-034 In REQ, ION=0 with ACK=1 -> IDLE, INTRQ=0 next cycle, PID unchanged.
REQ-035 IREQ[5] and CLRPID with FIDB=0x0020 same cycle -> PID[5]=1; with CGA_INTR_ACK_CLR_EN, ACK on level 5 -> PID[5]=0.
REQ-036 RESETN asserted asynchronously while INTRQ=1 -> INTRQ, PIDO, PIEO all 0 before the next MCLK edge.
